// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory responder: request size encodings,
// FSM state values and big-endian word/byte helpers.
package mem_pkg;

    localparam logic [1:0] SIZE_1W  = 2'b00;
    localparam logic [1:0] SIZE_4W  = 2'b01;
    localparam logic [1:0] SIZE_8W  = 2'b10;
    localparam logic [1:0] SIZE_16W = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    // Number of beats a request of the given access_size produces.
    function automatic logic [4:0] beat_count(input logic [1:0] size);
        case (size)
            SIZE_1W: return 5'd1;
            SIZE_4W: return 5'd4;
            SIZE_8W: return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

    // Assemble a word from four consecutive bytes; the lowest address is the MSB.
    function automatic logic [31:0] be_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte of a word that lands at byte offset idx (0 = lowest address = MSB).
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage: combinational big-endian word read and a clocked
// word write, both at a byte index that the caller keeps word aligned.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1048576,
    parameter int          AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data
);

    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] rd_bytes [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd
            assign rd_bytes[gi] = mem[index + AW'(gi)];
        end
    endgenerate

    assign rd_data = be_word(rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]);

    // Write all four bytes of the word in big-endian order.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                mem[index + AW'(i)] <= be_byte(wr_data, 2'(i));
            end
        end
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory responder for the pipeline request protocol: single-word and burst
// reads/writes with per-beat range checking, busy during bursts.
module burst_mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] base_addr    = 32'h80020000,
    parameter int unsigned memory_depth = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [1:0]  access_size,
    input  logic        rw,
    input  logic        enable,
    output logic        busy,
    output logic [31:0] data_out,
    output logic        valid,
    output logic        error
);

    localparam int AW = $clog2(memory_depth);
    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_BURST = BURST;

    logic [0:0]  state_reg;
    logic [3:0]  count_reg;
    logic [4:0]  len_reg;
    logic [31:0] addr_reg;
    logic        rw_reg;
    logic [31:0] data_out_reg;
    logic        valid_reg;
    logic        error_reg;

    logic        beat_go;
    logic        beat_rw;
    logic [31:0] beat_addr;
    logic [31:0] beat_offset;
    logic        beat_oor;
    logic        wr_en;
    logic [31:0] rd_word;

    // Select what the beat at the coming edge does: the new request in IDLE,
    // or the next latched-address beat while a burst is running.
    always_comb begin
        beat_go   = 1'b0;
        beat_rw   = rw_reg;
        beat_addr = addr_reg + {26'd0, count_reg, 2'b00};
        if (state_reg == ST_BURST) begin
            beat_go = 1'b1;
        end else if (enable) begin
            beat_go   = 1'b1;
            beat_rw   = rw;
            beat_addr = address & ~32'h3;
        end
    end

    // Offset is computed in 33 bits so offset+3 cannot wrap past the limit.
    assign beat_offset = beat_addr - base_addr;
    assign beat_oor    = (beat_addr < base_addr) ||
                         (({1'b0, beat_offset} + 33'd3) >= 33'(memory_depth));
    // Reset wins over any beat, so nothing is written on a reset edge.
    assign wr_en       = beat_go && !beat_rw && !beat_oor && !reset;

    mem_byte_array #(
        .DEPTH (memory_depth),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .index   (beat_offset[AW-1:0]),
        .wr_data (data_in),
        .rd_data (rd_word)
    );

    // Request acceptance and burst sequencing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= 4'd0;
            len_reg   <= 5'd0;
            addr_reg  <= 32'd0;
            rw_reg    <= 1'b0;
        end else if (state_reg == ST_IDLE) begin
            if (enable) begin
                addr_reg <= beat_addr;
                rw_reg   <= rw;
                len_reg  <= beat_count(access_size);
                if (access_size != SIZE_1W) begin
                    state_reg <= ST_BURST;
                    count_reg <= 4'd1;
                end
            end
        end else begin
            if ({1'b0, count_reg} == len_reg - 5'd1) begin
                state_reg <= ST_IDLE;
                count_reg <= 4'd0;
            end else begin
                count_reg <= count_reg + 4'd1;
            end
        end
    end

    // Output registers: read data/valid per read beat, error per any beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_reg <= 32'd0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
        end else if (beat_go) begin
            error_reg <= beat_oor;
            if (beat_rw) begin
                data_out_reg <= beat_oor ? 32'd0 : rd_word;
                valid_reg    <= 1'b1;
            end else begin
                valid_reg <= 1'b0;
            end
        end else begin
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
        end
    end

    assign busy     = (state_reg == ST_BURST);
    assign data_out = data_out_reg;
    assign valid    = valid_reg;
    assign error    = error_reg;

endmodule
